// File: rtl/sdram_wr_burst_ctrl_if.sv
// Bundle of FIFO read-port and SDRAM write-controller signals for sdram_wr_burst_ctrl.
// master: the burst controller; slave: the FIFO/controller environment.
interface sdram_wr_burst_ctrl_if #(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned LEN_W  = 10
);
    logic              flush;
    logic [15:0]       fifo_dout;
    logic              fifo_empty;
    logic [LEN_W-1:0]  fifo_rdusedw;
    logic              fifo_re;
    logic              sdram_wr_req;
    logic [ADDR_W-1:0] sdram_wr_addr;
    logic [LEN_W-1:0]  sdram_wr_len;
    logic              sdram_wr_ack;
    logic              sdram_wr_data_req;
    logic [15:0]       sdram_wr_data;
    logic              burst_done;
    logic              busy;
    logic              underrun;

    modport master (
        input  flush, fifo_dout, fifo_empty, fifo_rdusedw, sdram_wr_ack, sdram_wr_data_req,
        output fifo_re, sdram_wr_req, sdram_wr_addr, sdram_wr_len, sdram_wr_data,
               burst_done, busy, underrun
    );

    modport slave (
        output flush, fifo_dout, fifo_empty, fifo_rdusedw, sdram_wr_ack, sdram_wr_data_req,
        input  fifo_re, sdram_wr_req, sdram_wr_addr, sdram_wr_len, sdram_wr_data,
               burst_done, busy, underrun
    );
endinterface

// File: rtl/sdram_wr_burst_ctrl.sv
// Drains a show-ahead write FIFO into fixed-length SDRAM write bursts at a wrapping
// linear address; partial bursts are issued only while flush is held.
module sdram_wr_burst_ctrl #(
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned BURST_LEN = 256,
    parameter int unsigned LEN_W     = 10,
    parameter int unsigned ADDR_MIN  = 0,
    parameter int unsigned ADDR_MAX  = 32'h000F_FFFF
) (
    input logic                   clk,
    input logic                   rst,
    sdram_wr_burst_ctrl_if.master bus
);

    localparam logic [LEN_W-1:0]  BurstLen  = LEN_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] AddrMin   = ADDR_W'(ADDR_MIN);
    // Highest start address that still leaves room for a full burst.
    localparam logic [ADDR_W:0]   AddrLimit = (ADDR_W + 1)'(ADDR_MAX - BURST_LEN + 1);

    typedef enum logic [1:0] {StIdle, StReq, StBurst, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              underrun_q, underrun_d;
    logic [ADDR_W:0]   addr_sum;

    assign addr_sum = {1'b0, addr_q} + (ADDR_W + 1)'(len_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= AddrMin;
            len_q      <= '0;
            cnt_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        underrun_d = underrun_q;
        unique case (state_q)
            StIdle: begin
                if (bus.fifo_rdusedw >= BurstLen) begin
                    len_d   = BurstLen;
                    state_d = StReq;
                end else if (bus.flush && !bus.fifo_empty) begin
                    len_d   = (bus.fifo_rdusedw > BurstLen) ? BurstLen : bus.fifo_rdusedw;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (bus.sdram_wr_ack) begin
                    cnt_d   = len_q;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                // Strobes on an empty FIFO still count so the controller's burst completes.
                if (bus.sdram_wr_data_req) begin
                    cnt_d = cnt_q - 1'b1;
                    if (bus.fifo_empty) underrun_d = 1'b1;
                    if (cnt_q == LEN_W'(1)) state_d = StDone;
                end
            end
            StDone: begin
                addr_d  = (addr_sum > AddrLimit) ? AddrMin : addr_sum[ADDR_W-1:0];
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.fifo_re       = (state_q == StBurst) && bus.sdram_wr_data_req && !bus.fifo_empty;
    assign bus.sdram_wr_data = ((state_q == StBurst) && !bus.fifo_empty) ? bus.fifo_dout : 16'h0;
    assign bus.sdram_wr_req  = (state_q == StReq);
    assign bus.sdram_wr_addr = addr_q;
    assign bus.sdram_wr_len  = len_q;
    assign bus.burst_done    = (state_q == StDone);
    assign bus.busy          = (state_q != StIdle);
    assign bus.underrun      = underrun_q;

endmodule

// File: tb/tb_sdram_wr_burst_ctrl.sv
// Directed bench for sdram_wr_burst_ctrl with a behavioural show-ahead FIFO.
module tb_sdram_wr_burst_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sdram_wr_burst_ctrl_if #(.ADDR_W(24), .LEN_W(10)) bus ();

    sdram_wr_burst_ctrl #(
        .ADDR_W(24), .BURST_LEN(256), .LEN_W(10), .ADDR_MIN(0), .ADDR_MAX(32'h3FF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Show-ahead FIFO model.
    logic [15:0] mem [0:1023];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    logic        fifo_clr = 1'b0;
    logic        force_empty = 1'b0;

    assign bus.fifo_empty   = force_empty || (wr_ptr == rd_ptr);
    assign bus.fifo_rdusedw = 10'(wr_ptr - rd_ptr);
    assign bus.fifo_dout    = mem[rd_ptr[9:0]];

    always @(posedge clk) begin
        if (fifo_clr) rd_ptr <= wr_ptr;
        else if (bus.fifo_re) rd_ptr <= rd_ptr + 1;
    end

    int checks = 0;
    int errors = 0;
    int push_val = 0;
    int pop_val = 0;
    int re_cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[9:0]] = 16'(push_val);
            push_val++;
            wr_ptr++;
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!bus.sdram_wr_req && n < 40) begin
            tick();
            n++;
        end
        check({tag, " req"}, 64'(bus.sdram_wr_req), 64'(1));
    endtask

    task automatic strobe(input string tag);
        bus.sdram_wr_data_req = 1'b1;
        #1;
        check({tag, " data"}, 64'(bus.sdram_wr_data), 64'(16'(pop_val)));
        if (bus.fifo_re) re_cnt++;
        pop_val++;
        tick();
        bus.sdram_wr_data_req = 1'b0;
    endtask

    task automatic run_burst(input string tag, input logic [23:0] exp_addr, input int exp_len,
                             input int ack_delay, input bit gaps);
        wait_req(tag);
        check({tag, " addr"}, 64'(bus.sdram_wr_addr), 64'(exp_addr));
        check({tag, " len"}, 64'(bus.sdram_wr_len), 64'(exp_len));
        for (int d = 0; d < ack_delay; d++) begin
            tick();
            check({tag, " hold"}, {29'd0, bus.sdram_wr_req, bus.sdram_wr_addr, bus.sdram_wr_len},
                  {29'd0, 1'b1, exp_addr, 10'(exp_len)});
        end
        bus.sdram_wr_ack = 1'b1;
        tick();
        bus.sdram_wr_ack = 1'b0;
        re_cnt = 0;
        for (int i = 0; i < exp_len; i++) begin
            strobe(tag);
            if (gaps && i != exp_len - 1) tick();
        end
        #1;
        check({tag, " done"}, 64'(bus.burst_done), 64'(1));
        check({tag, " re count"}, 64'(re_cnt), 64'(exp_len));
        tick();
        check({tag, " done low"}, 64'({bus.burst_done, bus.busy}), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.sdram_wr_ack = 1'b0;
        bus.sdram_wr_data_req = 1'b0;
        tick();
        tick();
        check("rst fifo_re", 64'(bus.fifo_re), 64'(0));
        check("rst req", 64'(bus.sdram_wr_req), 64'(0));
        check("rst flags", 64'({bus.burst_done, bus.busy, bus.underrun}), 64'(0));
        check("rst data", 64'(bus.sdram_wr_data), 64'(0));
        check("rst len", 64'(bus.sdram_wr_len), 64'(0));
        check("rst addr", 64'(bus.sdram_wr_addr), 64'(0));
        rst = 1'b0;

        // Full burst leaves 44 words and no new request.
        fill(300);
        run_burst("full", 24'h000000, 256, 0, 1'b0);
        check("full remain", 64'(bus.fifo_rdusedw), 64'(44));
        check("full next addr", 64'(bus.sdram_wr_addr), 64'(24'h000100));
        repeat (5) tick();
        check("full no req", 64'({bus.sdram_wr_req, bus.busy}), 64'(0));

        // Flush drains the remaining 44 words.
        bus.flush = 1'b1;
        run_burst("flush", 24'h000100, 44, 0, 1'b0);
        bus.flush = 1'b0;
        check("flush next addr", 64'(bus.sdram_wr_addr), 64'(24'h00012C));
        check("flush empty", 64'(bus.fifo_empty), 64'(1));

        // Wrap over a 1K-word region.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("wrap rst addr", 64'(bus.sdram_wr_addr), 64'(0));
        for (int b = 0; b < 4; b++) begin
            fill(256);
            run_burst("wrap", 24'(b * 256), 256, 0, 1'b0);
        end
        fill(256);
        run_burst("wrap5", 24'h000000, 256, 0, 1'b0);

        // Late ack and gapped strobes.
        fill(256);
        run_burst("gaps", 24'h000100, 256, 10, 1'b1);

        // Underrun on a 4-word flush burst; flush drop must not cancel it.
        fill(4);
        bus.flush = 1'b1;
        wait_req("ur");
        check("ur len", 64'(bus.sdram_wr_len), 64'(4));
        check("ur addr", 64'(bus.sdram_wr_addr), 64'(24'h000200));
        bus.flush = 1'b0;
        tick();
        check("ur req kept", 64'({bus.sdram_wr_req, bus.sdram_wr_len}), 64'({1'b1, 10'd4}));
        bus.sdram_wr_ack = 1'b1;
        tick();
        bus.sdram_wr_ack = 1'b0;
        re_cnt = 0;
        strobe("ur s1");
        strobe("ur s2");
        check("ur re 2", 64'(re_cnt), 64'(2));
        check("ur not yet", 64'(bus.underrun), 64'(0));
        force_empty = 1'b1;
        for (int s = 0; s < 2; s++) begin
            bus.sdram_wr_data_req = 1'b1;
            #1;
            check("ur re", 64'(bus.fifo_re), 64'(0));
            check("ur data", 64'(bus.sdram_wr_data), 64'(0));
            tick();
            bus.sdram_wr_data_req = 1'b0;
            check("ur sticky", 64'(bus.underrun), 64'(1));
        end
        #1;
        check("ur done", 64'(bus.burst_done), 64'(1));
        tick();
        force_empty = 1'b0;
        repeat (4) tick();
        check("ur idle", 64'({bus.sdram_wr_req, bus.busy, bus.underrun}), 64'(3'b001));

        // Reset in the middle of a burst.
        rst = 1'b1;
        fifo_clr = 1'b1;
        tick();
        rst = 1'b0;
        fifo_clr = 1'b0;
        pop_val = push_val;
        check("mid rst underrun", 64'(bus.underrun), 64'(0));
        fill(300);
        bus.sdram_wr_ack = 1'b0;
        wait_req("mid");
        check("mid addr", 64'(bus.sdram_wr_addr), 64'(0));
        bus.sdram_wr_ack = 1'b1;
        tick();
        bus.sdram_wr_ack = 1'b0;
        re_cnt = 0;
        for (int i = 0; i < 100; i++) strobe("mid");
        check("mid re 100", 64'(re_cnt), 64'(100));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid state", 64'({bus.busy, bus.sdram_wr_req, bus.burst_done}), 64'(0));
        check("mid addr min", 64'(bus.sdram_wr_addr), 64'(0));
        bus.sdram_wr_data_req = 1'b1;
        re_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.fifo_re) re_cnt++;
            tick();
        end
        bus.sdram_wr_data_req = 1'b0;
        check("mid no re", 64'(re_cnt), 64'(0));
        check("mid fifo kept", 64'(bus.fifo_rdusedw), 64'(200));
        check("mid stays idle", 64'(bus.busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
